demux8_router: RTL and testbench



---
 rtl/demux8_router.sv | 88 ++++++++
 tb/tb_demux8_router.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/demux8_router.sv
// Registered 1:8 demultiplexer with one holding register per output channel.
// Optional transfer counter enabled by defining DEMUX8_CNT_EN; otherwise xfer_count_o is tied to zero.
module demux8_router #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic [2:0]       in_sel_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [WIDTH-1:0] y_a_o,
  output logic [WIDTH-1:0] y_b_o,
  output logic [WIDTH-1:0] y_c_o,
  output logic [WIDTH-1:0] y_d_o,
  output logic [WIDTH-1:0] y_e_o,
  output logic [WIDTH-1:0] y_f_o,
  output logic [WIDTH-1:0] y_g_o,
  output logic [WIDTH-1:0] y_h_o,
  output logic [7:0]       out_valid_o,
  input  logic [7:0]       out_ready_i,
  output logic [15:0]      xfer_count_o
);

  logic             accept;
  logic [7:0]       valid_w;
  logic [WIDTH-1:0] y_w [8];

  // Ready looks only at the selected channel, so a stalled channel never blocks the others.
  assign in_ready_o = ~valid_w[in_sel_i] | out_ready_i[in_sel_i];
  assign accept     = in_valid_i & in_ready_o;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_chan
      logic             load;
      logic             valid_q, valid_d;
      logic [WIDTH-1:0] y_q, y_d;

      assign load = accept && (in_sel_i == 3'(gi));

      // A load wins over a same-cycle drain, giving drain-plus-reload with no bubble.
      always_comb begin
        valid_d = load | (valid_q & ~out_ready_i[gi]);
        y_d     = load ? in_data_i : y_q;
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          valid_q <= 1'b0;
          y_q     <= '0;
        end else begin
          valid_q <= valid_d;
          y_q     <= y_d;
        end
      end

      assign valid_w[gi] = valid_q;
      assign y_w[gi]     = y_q;
    end
  endgenerate

  assign out_valid_o = valid_w;
  assign y_a_o = y_w[0];
  assign y_b_o = y_w[1];
  assign y_c_o = y_w[2];
  assign y_d_o = y_w[3];
  assign y_e_o = y_w[4];
  assign y_f_o = y_w[5];
  assign y_g_o = y_w[6];
  assign y_h_o = y_w[7];

`ifdef DEMUX8_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  // Wraps naturally at 16 bits.
  assign cnt_d = cnt_q + 16'(accept);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign xfer_count_o = cnt_q;
`else
  assign xfer_count_o = 16'h0000;
`endif

endmodule

// File: tb/tb_demux8_router.sv
// Self-checking bench for demux8_router: directed scenarios with literal expectations plus
// randomized traffic checked each cycle against a channel-occupancy model.
module tb_demux8_router;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  in_data;
  logic [2:0]  in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  y_a, y_b, y_c, y_d, y_e, y_f, y_g, y_h;
  logic [7:0]  out_valid;
  logic [7:0]  out_ready;
  logic [15:0] xfer_count;
  logic [7:0]  dut_y [8];

  int tests = 0;
  int fails = 0;
  bit verbose = 1'b1;

  // Behavioural model: which channels hold a word, what they hold, and how many accepts occurred.
  bit          m_valid [8];
  logic [7:0]  m_y [8];
  logic [15:0] m_cnt;
  logic        last_rdy;

  always #5 clk = ~clk;

  demux8_router #(.WIDTH(8)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .in_data_i(in_data), .in_sel_i(in_sel), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .y_a_o(y_a), .y_b_o(y_b), .y_c_o(y_c), .y_d_o(y_d),
    .y_e_o(y_e), .y_f_o(y_f), .y_g_o(y_g), .y_h_o(y_h),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .xfer_count_o(xfer_count)
  );

  assign dut_y[0] = y_a; assign dut_y[1] = y_b; assign dut_y[2] = y_c; assign dut_y[3] = y_d;
  assign dut_y[4] = y_e; assign dut_y[5] = y_f; assign dut_y[6] = y_g; assign dut_y[7] = y_h;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_valid_vec();
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = m_valid[i];
    return v;
  endfunction

  function automatic logic [15:0] exp_count();
`ifdef DEMUX8_CNT_EN
    return m_cnt;
`else
    return 16'h0000;
`endif
  endfunction

  task automatic compare_state();
    check("out_valid", {24'd0, out_valid}, {24'd0, model_valid_vec()});
    for (int i = 0; i < 8; i++)
      check($sformatf("y[%0d]", i), {24'd0, dut_y[i]}, {24'd0, m_y[i]});
    check("xfer_count", {16'd0, xfer_count}, {16'd0, exp_count()});
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1'b0;
      m_y[i]     = 8'h00;
    end
    m_cnt = 16'h0000;
  endtask

  // One cycle: check registered outputs, drive inputs, check ready, then advance the model at the edge.
  task automatic step(input logic v, input logic [2:0] s, input logic [7:0] d, input logic [7:0] r);
    bit exp_rdy, acc;
    @(negedge clk);
    compare_state();
    in_valid = v; in_sel = s; in_data = d; out_ready = r;
    #1;
    exp_rdy = !m_valid[s] || r[s];
    check("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    last_rdy = in_ready;
    acc = v && exp_rdy;
    if (verbose)
      $display("[TB] valid=%0b sel=%0d data=%02h out_ready=%02h ready=%0b accept=%0b",
               v, s, d, r, in_ready, acc);
    @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      if (acc && s == 3'(i)) begin
        m_valid[i] = 1'b1;
        m_y[i]     = d;
      end else if (r[i]) begin
        m_valid[i] = 1'b0;
      end
    end
    if (acc) m_cnt = m_cnt + 16'd1;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sel = 3'd0; in_data = 8'h00; out_ready = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", {24'd0, out_valid}, 32'h00);
    check("reset_xfer_count", {16'd0, xfer_count}, 32'h0);
    check("reset_in_ready", {31'd0, in_ready}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;

    // Sweep: one word per channel on consecutive cycles, all destinations ready.
    for (int s = 0; s < 8; s++) begin
      step(1'b1, 3'(s), 8'h10 + 8'(s), 8'hFF);
      check("sweep_y", {24'd0, dut_y[s]}, {24'd0, 8'h10 + 8'(s)});
      check("sweep_valid_pulse", {24'd0, out_valid}, {24'd0, 8'h01 << s});
    end
    step(1'b0, 3'd0, 8'h00, 8'hFF);
    check("sweep_drained", {24'd0, out_valid}, 32'h00);

    // Back-pressure on channel B.
    step(1'b1, 3'd1, 8'hAA, 8'h00);
    step(1'b1, 3'd1, 8'hBB, 8'h00);
    check("bp_ready_low", {31'd0, last_rdy}, 32'h0);
    check("bp_y_b_held", {24'd0, y_b}, 32'hAA);
    step(1'b1, 3'd1, 8'hBB, 8'h02);
    check("bp_ready_high", {31'd0, last_rdy}, 32'h1);
    check("bp_y_b_reload", {24'd0, y_b}, 32'hBB);
    check("bp_valid_b", {31'd0, out_valid[1]}, 32'h1);
    step(1'b0, 3'd0, 8'h00, 8'h02);

    // Isolation: D stalled while G loads.
    step(1'b1, 3'd3, 8'h33, 8'h00);
    step(1'b1, 3'd6, 8'h55, 8'h00);
    check("iso_ready", {31'd0, last_rdy}, 32'h1);
    check("iso_y_g", {24'd0, y_g}, 32'h55);
    check("iso_y_d", {24'd0, y_d}, 32'h33);
    step(1'b0, 3'd0, 8'h00, 8'hFF);

    // Simultaneous drain of A, E and H.
    step(1'b1, 3'd0, 8'hA1, 8'h00);
    step(1'b1, 3'd4, 8'hE5, 8'h00);
    step(1'b1, 3'd7, 8'hF8, 8'h00);
    check("sim_full", {24'd0, out_valid}, 32'h91);
    step(1'b0, 3'd0, 8'h00, 8'h91);
    check("sim_empty", {24'd0, out_valid}, 32'h00);
    check("sim_y_a", {24'd0, y_a}, 32'hA1);
    check("sim_y_e", {24'd0, y_e}, 32'hE5);
    check("sim_y_h", {24'd0, y_h}, 32'hF8);

    // Randomized traffic.
    verbose = 1'b0;
    for (int n = 0; n < 3000; n++)
      step(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 8'($urandom),
           8'($urandom) | 8'($urandom));
    verbose = 1'b1;

    // Asynchronous reset mid-stream with C and F full.
    step(1'b0, 3'd0, 8'h00, 8'hFF);
    step(1'b1, 3'd2, 8'hC3, 8'h00);
    step(1'b1, 3'd5, 8'hF6, 8'h00);
    check("rst_pre_full", {24'd0, out_valid & 8'h24}, 32'h24);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_valid", {24'd0, out_valid}, 32'h00);
    for (int i = 0; i < 8; i++) check("rst_async_y", {24'd0, dut_y[i]}, 32'h00);
    check("rst_async_count", {16'd0, xfer_count}, 32'h0);
    for (int s = 0; s < 8; s++) begin
      in_sel = 3'(s);
      #1;
      check("rst_async_ready", {31'd0, in_ready}, 32'h1);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

`ifdef DEMUX8_CNT_EN
    verbose = 1'b0;
    for (int n = 0; n < 65534; n++) step(1'b1, 3'd0, 8'(n), 8'hFF);
    verbose = 1'b1;
    step(1'b1, 3'd0, 8'h5A, 8'hFF);
    check("cnt_ffff", {16'd0, xfer_count}, 32'hFFFF);
    step(1'b1, 3'd0, 8'h5B, 8'hFF);
    check("cnt_wrap", {16'd0, xfer_count}, 32'h0000);
`else
    step(1'b1, 3'd0, 8'h5A, 8'hFF);
    step(1'b1, 3'd1, 8'h5B, 8'hFF);
    check("cnt_tied_zero", {16'd0, xfer_count}, 32'h0000);
`endif
    step(1'b0, 3'd0, 8'h00, 8'hFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
